// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline definitions: result-select codes, load funct3
// encodings and the datapath width.
package cpu_pkg;

  localparam int XLEN = 32;

  // Writeback result select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // Load size/sign encodings (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_fmt.sv
// Load data formatter: extracts a byte or halfword from an aligned memory
// word and sign- or zero-extends it. Purely combinational.
module load_fmt
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/half, then extend according to funct3
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = '0;

    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase

    // off[0] is ignored for halves; misaligned accesses never get this far
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_word;
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result mux, register-file
// write port, EX forwarding tap and retired-instruction counter.
module wb_stage
  import cpu_pkg::WB_ALU;
  import cpu_pkg::WB_LOAD;
  import cpu_pkg::WB_PC4;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             mem_valid,
  input  logic             mem_regWrite,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wbSel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_aluResult,
  input  logic [XLEN-1:0]  mem_loadData,
  input  logic [XLEN-1:0]  mem_pcPlus4,
  output logic             isWrite,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  writeData,
  output logic             wb_valid,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  logic             r_valid;
  logic             r_regWrite;
  logic [4:0]       r_rd;
  logic [1:0]       r_wbSel;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_aluResult;
  logic [XLEN-1:0]  r_loadData;
  logic [XLEN-1:0]  r_pcPlus4;
  logic [CNT_W-1:0] r_instret;

  logic [XLEN-1:0]  w_load_fmt;
  logic [XLEN-1:0]  w_result;
  logic             w_sel_ok;
  logic             w_is_write;

  // MEM/WB register: reset clears everything, stall holds, otherwise capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_regWrite  <= 1'b0;
      r_rd        <= 5'd0;
      r_wbSel     <= 2'b00;
      r_funct3    <= 3'b000;
      r_aluResult <= '0;
      r_loadData  <= '0;
      r_pcPlus4   <= '0;
    end else if (!stall) begin
      r_valid     <= mem_valid;
      r_regWrite  <= mem_regWrite;
      r_rd        <= mem_rd;
      r_wbSel     <= mem_wbSel;
      r_funct3    <= mem_funct3;
      r_aluResult <= mem_aluResult;
      r_loadData  <= mem_loadData;
      r_pcPlus4   <= mem_pcPlus4;
    end
  end

  // Retire counter: an instruction retires when it leaves WB un-stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
    end else if (!stall && r_valid) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Load formatting works off the registered word so outputs never see mem_*
  load_fmt u_load_fmt (
    .i_word   (r_loadData),
    .i_off    (r_aluResult[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load_fmt)
  );

  // Result select; the reserved code yields zero and blocks the write
  always_comb begin
    w_result = '0;
    w_sel_ok = 1'b0;
    case (r_wbSel)
      WB_ALU: begin
        w_result = r_aluResult;
        w_sel_ok = 1'b1;
      end
      WB_LOAD: begin
        w_result = w_load_fmt;
        w_sel_ok = 1'b1;
      end
      WB_PC4: begin
        w_result = r_pcPlus4;
        w_sel_ok = 1'b1;
      end
      default: begin
        w_result = '0;
        w_sel_ok = 1'b0;
      end
    endcase
  end

  // x0 is never written; bubbles and non-writing instructions are masked
  assign w_is_write = r_valid & r_regWrite & (r_rd != 5'd0) & w_sel_ok;

  assign isWrite   = w_is_write;
  assign rd        = r_rd;
  assign writeData = w_result;
  assign wb_valid  = r_valid;
  assign fwd_valid = w_is_write;
  assign fwd_rd    = r_rd;
  assign fwd_data  = w_result;
  assign instret   = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table of single-instruction vectors,
// a scoreboard of expected write-port values, plus hand-written stall,
// counter-wrap and reset-during-stall sequences. A second instance with a
// 4-bit counter exercises instret wrap-around.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        mem_valid, mem_regWrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbSel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_aluResult, mem_loadData, mem_pcPlus4;

  logic        isWrite, wb_valid, fwd_valid;
  logic [4:0]  rd, fwd_rd;
  logic [31:0] writeData, fwd_data, instret;

  logic        n_isWrite, n_wb_valid, n_fwd_valid;
  logic [4:0]  n_rd, n_fwd_rd;
  logic [31:0] n_writeData, n_fwd_data;
  logic [3:0]  n_instret;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_valid(mem_valid), .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
    .mem_wbSel(mem_wbSel), .mem_funct3(mem_funct3),
    .mem_aluResult(mem_aluResult), .mem_loadData(mem_loadData),
    .mem_pcPlus4(mem_pcPlus4),
    .isWrite(isWrite), .rd(rd), .writeData(writeData), .wb_valid(wb_valid),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret)
  );

  wb_stage #(.XLEN(32), .CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_valid(mem_valid), .mem_regWrite(mem_regWrite), .mem_rd(mem_rd),
    .mem_wbSel(mem_wbSel), .mem_funct3(mem_funct3),
    .mem_aluResult(mem_aluResult), .mem_loadData(mem_loadData),
    .mem_pcPlus4(mem_pcPlus4),
    .isWrite(n_isWrite), .rd(n_rd), .writeData(n_writeData),
    .wb_valid(n_wb_valid), .fwd_valid(n_fwd_valid), .fwd_rd(n_fwd_rd),
    .fwd_data(n_fwd_data), .instret(n_instret)
  );

  typedef struct {
    string       name;
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
    logic        exp_w;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    logic        w;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        v;
  } exp_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference retire counter and the valid bit it sits behind
  logic [31:0] m_cnt = 32'd0;
  logic        m_valid = 1'b0;

  localparam logic [31:0] LD = 32'h80FF_7F01;

  function automatic vec_t mkv(string n, logic v, logic rw, logic [4:0] r,
                               logic [1:0] s, logic [2:0] f, logic [31:0] a,
                               logic [31:0] p, logic ew, logic [31:0] ed);
    vec_t t;
    t.name = n; t.v = v; t.rw = rw; t.rd = r; t.sel = s; t.f3 = f;
    t.alu = a; t.ld = LD; t.pc4 = p; t.exp_w = ew; t.exp_d = ed;
    return t;
  endfunction

  task automatic cmp(string tag, string what, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", tag, what, act, exp);
    end
  endtask

  task automatic check_out(string tag, exp_t e);
    cmp(tag, "isWrite",   {31'b0, isWrite},   {31'b0, e.w});
    cmp(tag, "rd",        {27'b0, rd},        {27'b0, e.rd});
    cmp(tag, "writeData", writeData,          e.d);
    cmp(tag, "wb_valid",  {31'b0, wb_valid},  {31'b0, e.v});
    cmp(tag, "fwd_valid", {31'b0, fwd_valid}, {31'b0, e.w});
    cmp(tag, "fwd_rd",    {27'b0, fwd_rd},    {27'b0, e.rd});
    cmp(tag, "fwd_data",  fwd_data,           e.d);
    cmp(tag, "instret",   instret,            m_cnt);
    cmp(tag, "instret4",  {28'b0, n_instret}, {28'b0, m_cnt[3:0]});
    $display("txn %-12s isWrite=%0d rd=%0d data=%h valid=%0d instret=%0d narrow=%0d",
             tag, isWrite, rd, writeData, wb_valid, instret, n_instret);
  endtask

  task automatic drive(logic v, logic rw, logic [4:0] r, logic [1:0] s,
                       logic [2:0] f, logic [31:0] a, logic [31:0] l, logic [31:0] p);
    mem_valid = v; mem_regWrite = rw; mem_rd = r; mem_wbSel = s;
    mem_funct3 = f; mem_aluResult = a; mem_loadData = l; mem_pcPlus4 = p;
  endtask

  // One clock edge, then advance the reference counter the way the
  // pipeline register should have moved
  task automatic tick();
    logic in_v;
    in_v = mem_valid;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 32'd0;
      m_valid = 1'b0;
    end else if (!stall) begin
      if (m_valid) m_cnt = m_cnt + 32'd1;
      m_valid = in_v;
    end
  endtask

  initial begin
    exp_t e;
    exp_t zero_e;
    zero_e = '{w: 1'b0, rd: 5'd0, d: 32'h0, v: 1'b0};

    vecs[0]  = mkv("alu_rd5",  1, 1, 5, 2'b00, 3'b010, 32'h1234_5678, 32'h0, 1, 32'h1234_5678);
    vecs[1]  = mkv("lb_off3",  1, 1, 2, 2'b01, 3'b000, 32'h0000_1003, 32'h0, 1, 32'hFFFF_FF80);
    vecs[2]  = mkv("lbu_off1", 1, 1, 2, 2'b01, 3'b100, 32'h0000_1001, 32'h0, 1, 32'h0000_007F);
    vecs[3]  = mkv("lh_off2",  1, 1, 2, 2'b01, 3'b001, 32'h0000_1002, 32'h0, 1, 32'hFFFF_80FF);
    vecs[4]  = mkv("lhu_off0", 1, 1, 2, 2'b01, 3'b101, 32'h0000_1000, 32'h0, 1, 32'h0000_7F01);
    vecs[5]  = mkv("lw",       1, 1, 2, 2'b01, 3'b010, 32'h0000_1000, 32'h0, 1, 32'h80FF_7F01);
    vecs[6]  = mkv("lb_off0",  1, 1, 3, 2'b01, 3'b000, 32'h0000_2000, 32'h0, 1, 32'h0000_0001);
    vecs[7]  = mkv("lb_off2",  1, 1, 3, 2'b01, 3'b000, 32'h0000_2002, 32'h0, 1, 32'hFFFF_FFFF);
    vecs[8]  = mkv("lbu_off3", 1, 1, 3, 2'b01, 3'b100, 32'h0000_2003, 32'h0, 1, 32'h0000_0080);
    vecs[9]  = mkv("lh_off3",  1, 1, 3, 2'b01, 3'b001, 32'h0000_2003, 32'h0, 1, 32'hFFFF_80FF);
    vecs[10] = mkv("lhu_off2", 1, 1, 3, 2'b01, 3'b101, 32'h0000_2002, 32'h0, 1, 32'h0000_80FF);
    vecs[11] = mkv("f3_011",   1, 1, 3, 2'b01, 3'b011, 32'h0000_2001, 32'h0, 1, 32'h80FF_7F01);
    vecs[12] = mkv("x0_sup",   1, 1, 0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF);
    vecs[13] = mkv("sel_rsv",  1, 1, 3, 2'b11, 3'b000, 32'h1111_2222, 32'h3333_4444, 0, 32'h0);
    vecs[14] = mkv("jal_link", 1, 1, 1, 2'b10, 3'b000, 32'h0000_0200, 32'h0000_0104, 1, 32'h0000_0104);
    vecs[15] = mkv("no_rw",    1, 0, 4, 2'b00, 3'b000, 32'h0BAD_CAFE, 32'h0, 0, 32'h0BAD_CAFE);
    vecs[16] = mkv("bubble",   0, 1, 6, 2'b00, 3'b000, 32'h7777_0000, 32'h0, 0, 32'h7777_0000);
    vecs[17] = mkv("alu_rd31", 1, 1, 31, 2'b00, 3'b000, 32'hCAFE_0031, 32'h0, 1, 32'hCAFE_0031);

    // Reset held for two cycles with junk on the inputs
    rst = 1'b1;
    stall = 1'b0;
    drive(1, 1, 9, 2'b00, 3'b010, 32'hFFFF_FFFF, LD, 32'h4);
    tick();
    tick();
    check_out("reset", zero_e);
    rst = 1'b0;

    // Table-driven single-instruction vectors through the scoreboard
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].rd, vecs[i].sel, vecs[i].f3,
            vecs[i].alu, vecs[i].ld, vecs[i].pc4);
      sb.push_back('{w: vecs[i].exp_w, rd: vecs[i].rd, d: vecs[i].exp_d, v: vecs[i].v});
      tick();
      e = sb.pop_front();
      check_out(vecs[i].name, e);
    end

    // Stall: hold rd7/A5 while the inputs move to rd8/5A
    drive(1, 1, 7, 2'b00, 3'b000, 32'h0000_00A5, LD, 32'h0);
    sb.push_back('{w: 1'b1, rd: 5'd7, d: 32'h0000_00A5, v: 1'b1});
    tick();
    e = sb.pop_front();
    check_out("stall_cap", e);
    stall = 1'b1;
    drive(1, 1, 8, 2'b00, 3'b000, 32'h0000_005A, LD, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("stall_hold", e);
    end
    stall = 1'b0;
    sb.push_back('{w: 1'b1, rd: 5'd8, d: 32'h0000_005A, v: 1'b1});
    tick();
    e = sb.pop_front();
    check_out("stall_rel", e);

    // Run enough back-to-back retirements to wrap the 4-bit counter
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 9, 2'b00, 3'b000, 32'h0000_9000 + k, LD, 32'h0);
      sb.push_back('{w: 1'b1, rd: 5'd9, d: 32'h0000_9000 + k, v: 1'b1});
      tick();
      e = sb.pop_front();
      check_out("wrap_run", e);
    end

    // Reset while stalled clears the register and the counter
    stall = 1'b1;
    rst = 1'b1;
    drive(1, 1, 10, 2'b00, 3'b000, 32'h0000_1010, LD, 32'h0);
    tick();
    rst = 1'b0;
    check_out("rst_stall", zero_e);
    stall = 1'b0;
    drive(0, 0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    check_out("post_rst", zero_e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32I pipeline. Holds the MEM/WB pipeline register.
- Formats load data (byte/half/word, signed/unsigned) and selects the result source.
- Drives the register file write port (isWrite, rd, writeData).
- Also exports a forwarding tap for the EX bypass and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold MEM/WB register contents; no capture, no retire count.
- mem_valid  input  1  MEM stage presents a real instruction (0 = bubble).
- mem_regWrite  input  1  instruction writes rd.
- mem_rd  input  5  destination register.
- mem_wbSel  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- mem_funct3  input  3  load size/sign encoding.
- mem_aluResult  input  32  ALU result; for loads, the byte address.
- mem_loadData  input  32  aligned 32-bit word read from data memory.
- mem_pcPlus4  input  32  link value for JAL/JALR.
- isWrite  output  1  register file write enable.
- rd  output  5  register file write address.
- writeData  output  32  register file write data.
- wb_valid  output  1  WB register holds a real instruction.
- fwd_valid  output  1  forwarding tap valid; equals isWrite.
- fwd_rd  output  5  forwarding destination; equals rd.
- fwd_data  output  32  forwarding data; equals writeData.
- instret  output  CNT_W  count of instructions retired.

Behaviour:
- Reset (rst=1 at a clock edge) clears all registered fields to 0, including valid, regWrite, rd, wbSel and data. instret also clears to 0. rst overrides stall and all inputs.
- Outputs after reset: isWrite=0, rd=0, writeData=0, wb_valid=0, fwd_valid=0, fwd_rd=0, fwd_data=0, instret=0.
- Capture: if rst=0 and stall=0, all mem_* inputs are registered at the edge. Latency is 1 cycle from MEM inputs to write-port outputs.
- Stall: if stall=1, the register holds its contents. A held valid write re-asserts isWrite each cycle with identical data, which is idempotent.
- Outputs are combinational from registered state only. There is no combinational path from any mem_* input to any output.
- isWrite = valid & regWrite & (rd != 0). rd and writeData are driven regardless of isWrite.
- Result select on registered wbSel:
  - 00: aluResult.
  - 01: formatted load.
  - 10: pcPlus4.
  - 11: 32'h0, and isWrite is forced to 0.
- Load formatting uses off = aluResult[1:0]:
  - 000 LB: byte at off, sign-extended.
  - 001 LH: half at off[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte at off, zero-extended.
  - 101 LHU: half at off[1], zero-extended.
  - Other funct3: full word.
- Byte selection: off=0 → bits 7:0, 1 → 15:8, 2 → 23:16, 3 → 31:24. Halfword: off[1]=0 → bits 15:0, 1 → 31:16. off[0] is ignored for halves; misalignment is trapped upstream.
- instret increments by 1 on each edge where rst=0, stall=0 and wb_valid=1. It counts valid instructions, including those with rd=0 or regWrite=0.
- instret wraps from 2^CNT_W-1 to 0 with no flag.
- Bubbles (mem_valid=0) are captured as valid=0. Their data fields are captured but ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - WB_ALU=2'b00, WB_LOAD=2'b01, WB_PC4=2'b10.
  - F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN.
- Sub-module load_fmt: combinational (word, off, funct3) → formatted 32-bit value. It is reusable by any future LSU.
- wb_stage instantiates load_fmt and contains the register, the mux and the counter.

Test Plan:
- Reset hold, then ALU write: rst=1 for 2 cycles → all outputs 0. Then mem_valid=1, regWrite=1, rd=5, wbSel=00, aluResult=32'h1234_5678 → next cycle isWrite=1, rd=5, writeData=32'h1234_5678, instret=0, and instret=1 one edge later.
- Load formatting with mem_loadData=32'h80FF_7F01:
  - LB off=3 → 32'hFFFF_FF80.
  - LBU off=1 → 32'h0000_007F.
  - LH off=2 → 32'hFFFF_80FF.
  - LHU off=0 → 32'h0000_7F01.
  - LW → 32'h80FF_7F01.
- x0 suppression and reserved select:
  - rd=0 with regWrite=1, wbSel=00 → isWrite=0, but instret still increments.
  - wbSel=11, rd=3 → isWrite=0, writeData=0.
- Stall: capture rd=7 / 32'hA5; hold stall=1 for 3 cycles while mem_* inputs change to rd=8 / 32'h5A → outputs stay rd=7 / 32'hA5 and instret does not advance. On release, capture rd=8 next edge.
- JAL link and forward tap: wbSel=10, pcPlus4=32'h0000_0104, rd=1 → writeData=32'h104, and fwd_valid/fwd_rd/fwd_data mirror the write port.
- Counter wrap and reset mid-stall:
  - Preload via 2^32-1 valid retirements (or a forced value in the bench) → next retire gives instret=0.
  - Assert rst while stall=1 → wb_valid=0 and instret=0 after one edge.
